// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial sequencer for the shared 8-bit RAM port; MEM has priority over IF.
// Build option: define MEM_ARB_LOAD_EXT_EN to sign/zero-extend sub-word loads per mem_load_sign.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_load_sign,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din,
    output logic              stall_req
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_IF_RD  = 3'd1;
    localparam logic [2:0] S_MEM_RD = 3'd2;
    localparam logic [2:0] S_MEM_WR = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sign;
        logic [31:0]       wdata;
        logic              is_mem;
    } req_t;

    logic [2:0]  state;
    logic [2:0]  cnt;
    req_t        cur;
    logic [31:0] rbuf;
    logic [2:0]  nbytes;
    logic        ext_fill;
    logic [31:0] ld_word;

    assign stall_req = (mem_req & ~mem_done) | (if_req & ~if_done);

    always_comb begin
        nbytes = 3'd4;
        if (cur.is_mem) begin
            case (cur.size)
                2'b00:   nbytes = 3'd1;
                2'b01:   nbytes = 3'd2;
                default: nbytes = 3'd4;
            endcase
        end
    end

`ifdef MEM_ARB_LOAD_EXT_EN
    always_comb begin
        case (cur.size)
            2'b00:   ext_fill = cur.sign & rbuf[7];
            2'b01:   ext_fill = cur.sign & rbuf[15];
            default: ext_fill = 1'b0;
        endcase
    end
`else
    // Extension happens downstream; the latched sign bit is carried but not consumed.
    logic unused_sign;
    assign unused_sign = cur.sign;
    assign ext_fill    = 1'b0;
`endif

    always_comb begin
        case (cur.size)
            2'b00:   ld_word = {{24{ext_fill}}, rbuf[7:0]};
            2'b01:   ld_word = {{16{ext_fill}}, rbuf[15:0]};
            default: ld_word = rbuf;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            cur       <= '0;
            rbuf      <= 32'd0;
            ram_a     <= '0;
            ram_dout  <= 8'd0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            ram_wr   <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt  <= 3'd0;
                    rbuf <= 32'd0;
                    if (mem_req) begin
                        cur.addr   <= mem_addr;
                        cur.size   <= mem_size;
                        cur.sign   <= mem_load_sign;
                        cur.wdata  <= mem_wdata;
                        cur.is_mem <= 1'b1;
                        state      <= mem_we ? S_MEM_WR : S_MEM_RD;
                    end else if (if_req && !if_flush) begin
                        cur.addr   <= if_addr;
                        cur.size   <= 2'b10;
                        cur.sign   <= 1'b0;
                        cur.wdata  <= 32'd0;
                        cur.is_mem <= 1'b0;
                        state      <= S_IF_RD;
                    end
                end
                S_IF_RD, S_MEM_RD: begin
                    if (state == S_IF_RD && if_flush) begin
                        state <= S_IDLE;
                    end else begin
                        // Address k goes out at cnt==k; its byte returns one cycle later at cnt==k+1.
                        if (cnt < nbytes)
                            ram_a <= cur.addr + ADDR_W'(cnt);
                        for (int b = 0; b < 4; b++)
                            if ((cnt == 3'(b + 1)) && (cnt <= nbytes))
                                rbuf[8*b +: 8] <= ram_din;
                        if (cnt == nbytes + 3'd1) begin
                            state <= S_DONE;
                            if (cur.is_mem) begin
                                mem_done  <= 1'b1;
                                mem_rdata <= ld_word;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= rbuf;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_MEM_WR: begin
                    if (cnt < nbytes) begin
                        ram_a    <= cur.addr + ADDR_W'(cnt);
                        ram_dout <= cur.wdata[{cnt[1:0], 3'b000} +: 8];
                        ram_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end else begin
                        mem_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Gap cycle so the requester can drop its level request before IDLE samples again.
                    cnt   <= 3'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized IF/MEM traffic against a byte-array model.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0, if_flush = 1'b0, if_done;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [31:0]       if_data;
    logic              mem_req = 1'b0, mem_we = 1'b0, mem_load_sign = 1'b0, mem_done;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [1:0]        mem_size = 2'b00;
    logic [31:0]       mem_wdata = '0, mem_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout, ram_din;
    logic              ram_wr, stall_req;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_load_sign(mem_load_sign), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din),
        .stall_req(stall_req)
    );

    // RAM seen by the DUT (low 8 address bits) and the model's own copy of the same contents.
    logic [7:0] ram_mem [0:255];
    logic [7:0] ref_mem [0:255];
    assign ram_din = ram_mem[ram_a[7:0]];
    always @(posedge clk) if (ram_wr) ram_mem[ram_a[7:0]] <= ram_dout;

    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic is_load; logic [31:0] data; } mresp_t;
    wr_t         wq[$];
    mresp_t      mq[$];
    logic [31:0] ifq[$];

    int checks = 0, fails = 0, cyc = 0;
    int if_done_cnt = 0, mem_done_cnt = 0;
    logic prev_if_done = 1'b0, prev_mem_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
        ref_mem[a] = v;
        ram_mem[a] <= v;
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Expected load: N little-endian bytes from the model, upper bits filled per the build option.
    function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int n = nbytes_of(sz);
        logic [31:0] v = 32'd0;
        logic [31:0] t;
        logic do_ext;
`ifdef MEM_ARB_LOAD_EXT_EN
        do_ext = sg;
`else
        do_ext = 1'b0 & sg;
`endif
        for (int i = 0; i < n; i++) begin
            t = a + 32'(i);
            v[8*i +: 8] = ref_mem[t[7:0]];
        end
        if (do_ext && n < 4 && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic issue_if(input logic [31:0] a, input bit expect_done);
        if (expect_done) ifq.push_back(load_val(a, 2'b10, 1'b0));
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic issue_mem(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        mresp_t r;
        wr_t    w;
        logic [31:0] t;
        if (we) begin
            for (int i = 0; i < nbytes_of(sz); i++) begin
                t = a + 32'(i);
                ref_mem[t[7:0]] = wd[8*i +: 8];
                w.a = t;
                w.d = wd[8*i +: 8];
                wq.push_back(w);
            end
            r.is_load = 1'b0;
            r.data    = 32'd0;
        end else begin
            r.is_load = 1'b1;
            r.data    = load_val(a, sz, sg);
        end
        mq.push_back(r);
        mem_we = we; mem_size = sz; mem_load_sign = sg; mem_addr = a; mem_wdata = wd;
        mem_req = 1'b1;
    endtask

    task automatic wait_if(output int d);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!if_done && n < 400);
        if (!if_done) fail("if_done_timeout");
        d = cyc;
        if_req = 1'b0;
    endtask

    task automatic wait_mem(output int d);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!mem_done && n < 400);
        if (!mem_done) fail("mem_done_timeout");
        d = cyc;
        mem_req = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT writes RAM or pulses a done.
    always @(negedge clk) begin
        automatic wr_t    w;
        automatic mresp_t r;
        chk("stall_req", 32'(stall_req), 32'((mem_req & ~mem_done) | (if_req & ~if_done)));
        if (ram_wr) begin
            if (wq.size() == 0) fail("unexpected_ram_wr");
            else begin
                w = wq.pop_front();
                chk("wr_addr", ram_a, w.a);
                chk("wr_data", 32'(ram_dout), 32'(w.d));
            end
        end
        if (if_done) begin
            if_done_cnt++;
            chk("if_done_width", 32'(prev_if_done), 32'd0);
            if (ifq.size() == 0) fail("unexpected_if_done");
            else chk("if_data", if_data, ifq.pop_front());
        end
        if (mem_done) begin
            mem_done_cnt++;
            chk("mem_done_width", 32'(prev_mem_done), 32'd0);
            if (mq.size() == 0) fail("unexpected_mem_done");
            else begin
                r = mq.pop_front();
                if (r.is_load) chk("mem_rdata", mem_rdata, r.data);
            end
        end
        prev_if_done  = if_done;
        prev_mem_done = mem_done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d, di, dm, c0;
        logic [7:0]  v;
        logic [31:0] a, wd;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            set_byte(8'(i), v);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ram_a", ram_a, 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Word fetch at 0x100: address stepping, 6-edge latency, little-endian assembly.
        set_byte(8'h00, 8'h13); set_byte(8'h01, 8'h12);
        set_byte(8'h02, 8'h11); set_byte(8'h03, 8'h10);
        issue_if(32'h100, 1'b1);
        e0 = cyc + 1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("if_ram_a_step", ram_a, 32'h100 + 32'(k));
        end
        wait_if(d);
        chk("if_latency", 32'(d - e0), 32'd6);
        chk("if_word", if_data, 32'h10111213);
        repeat (2) begin @(posedge clk); #1; end

        // Simultaneous requests: MEM store wins, IF accepted two edges after mem_done.
        issue_if(32'h0, 1'b1);
        issue_mem(1'b1, 2'b10, 1'b0, 32'h20, 32'hAABBCCDD);
        e0 = cyc + 1;
        fork
            wait_mem(dm);
            wait_if(di);
        join
        chk("store_latency", 32'(dm - e0), 32'd5);
        chk("if_after_mem_latency", 32'(di - e0), 32'd13);
        repeat (2) begin @(posedge clk); #1; end

        // Signed byte load of 0x80.
        set_byte(8'h40, 8'h80);
        issue_mem(1'b0, 2'b00, 1'b1, 32'h40, 32'h0);
        e0 = cyc + 1;
        wait_mem(d);
        chk("lb_latency", 32'(d - e0), 32'd3);
`ifdef MEM_ARB_LOAD_EXT_EN
        chk("lb_sign_ext", mem_rdata, 32'hFFFFFF80);
`else
        chk("lb_zero_ext", mem_rdata, 32'h00000080);
`endif
        repeat (2) begin @(posedge clk); #1; end

        // Flush at k=2 of a fetch: no if_done, FSM free for a MEM request on the next edge.
        c0 = if_done_cnt;
        issue_if(32'h10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        if_req   = 1'b0;
        issue_mem(1'b0, 2'b01, 1'b0, 32'h84, 32'h0);
        e0 = cyc + 1;
        wait_mem(d);
        chk("after_flush_latency", 32'(d - e0), 32'd4);
        repeat (2) begin @(posedge clk); #1; end
        // Flush while idle blocks acceptance.
        issue_if(32'h30, 1'b0);
        if_flush = 1'b1;
        @(posedge clk); #1;
        if_flush = 1'b0;
        if_req   = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("flush_no_if_done", 32'(if_done_cnt), 32'(c0));

        // Half store wrapping at the top of the address space, then read back.
        issue_mem(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h12345678);
        e0 = cyc + 1;
        wait_mem(d);
        chk("sh_wrap_latency", 32'(d - e0), 32'd3);
        repeat (2) begin @(posedge clk); #1; end
        issue_mem(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0);
        wait_mem(d);
        chk("lh_wrap_data", mem_rdata, 32'h00005678);
        repeat (2) begin @(posedge clk); #1; end

        // Reset in the middle of a store; data equals current contents so the model stays valid.
        wd = load_val(32'h90, 2'b10, 1'b0);
        issue_mem(1'b1, 2'b10, 1'b0, 32'h90, wd);
        repeat (2) begin @(posedge clk); #1; end
        chk("store_wr_active", 32'(ram_wr), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("async_rst_ram_a", ram_a, 32'd0);
        chk("async_rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("async_rst_if_data", if_data, 32'd0);
        chk("async_rst_mem_rdata", mem_rdata, 32'd0);
        wq.delete();
        mq.delete();
        mem_req = 1'b0;
        c0 = mem_done_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        chk("no_mem_done_after_rst", 32'(mem_done_cnt), 32'(c0));

        // Random concurrent traffic: IF in low half of each 256-byte window, MEM in upper half.
        fork
            begin
                int dd;
                logic [31:0] ia;
                for (int n = 0; n < 20; n++) begin
                    repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
                    ia = $urandom;
                    ia[7:0] = 8'($urandom_range(0, 124));
                    issue_if(ia, 1'b1);
                    wait_if(dd);
                end
            end
            begin
                int dd;
                logic [31:0] ma;
                logic [1:0]  sz;
                for (int n = 0; n < 30; n++) begin
                    repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
                    ma = $urandom;
                    ma[7:0] = 8'($urandom_range(128, 252));
                    sz = 2'($urandom_range(0, 3));
                    issue_mem(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ma, $urandom);
                    wait_mem(dd);
                end
            end
        join
        repeat (5) begin @(posedge clk); #1; end
        chk("ifq_drained", 32'(ifq.size()), 32'd0);
        chk("mq_drained", 32'(mq.size()), 32'd0);
        chk("wq_drained", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single byte-wide RAM port shared by instruction fetch and the MEM stage fed by the EX/MEM pipeline register. It accepts one word-fetch request from IF and one load/store request from MEM, and grants the port to one requester at a time; MEM has priority. Each access is split into 1, 2 or 4 byte cycles, the bytes are reassembled, and the requester gets a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 32, RAM address width; all address arithmetic is modulo 2^ADDR_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_req  in  1  IF word-read request; level, held until if_done
- if_addr  in  ADDR_W  IF byte address
- if_flush  in  1  abort any IF fetch that is pending or in flight
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  32  fetched word, little-endian
- mem_req  in  1  MEM request; level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  MEM byte address
- mem_size  in  2  00 byte, 01 half, 10/11 word
- mem_load_sign  in  1  sign-extend a sub-word load
- mem_wdata  in  32  store data; low bytes used
- mem_done  out  1  one-cycle pulse; mem_rdata valid on loads
- mem_rdata  out  32  load result
- ram_a  out  ADDR_W  RAM address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe
- ram_din  in  8  RAM read byte; valid the cycle after ram_a
- stall_req  out  1  combinational; (mem_req & ~mem_done) | (if_req & ~if_done)

## Operation
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Requests are sampled only in IDLE. mem_req wins over if_req. Address, size, we, sign and wdata are latched on acceptance.
- N = 4 for IF; N = 1/2/4 for MEM according to mem_size.
- Byte counter k runs 0..N-1. ram_a = latched_addr + k, wrapping at 2^ADDR_W.
- MEM_RD and IF_RD:
  - Issue N addresses.
  - Byte k, sampled one cycle after its address was presented, goes to bits [8k+7:8k].
- MEM_WR: ram_wr = 1 and ram_dout = wdata[8k+7:8k] for each k.
- After the last byte the block enters DONE, which pulses the matching done for one cycle. DONE always moves to IDLE. The gap cycle lets the requester drop its request before the next sample.
- Load extension: bits above 8N are filled with bit 8N-1 when sign extension is enabled, otherwise with zero.
- Flush:
  - if_flush in IF_RD: go to IDLE at the next edge, with no if_done and if_data unchanged.
  - if_flush in IDLE: suppresses IF acceptance that edge.
  - if_flush in DONE: if_done still pulses; IF discards the word.
- MEM transactions are never aborted and never preempted.
- The RAM port is otherwise idle: ram_wr = 0, ram_a and ram_dout hold their last values.

## Timing
- All outputs except stall_req are registered.
- Reset values: state IDLE, ram_a 0, ram_dout 0, ram_wr 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0, counter 0.
- Reset asserted mid-transaction: abort immediately and drop ram_wr asynchronously; no done is issued.
- Acceptance at edge E0. ram_a = addr+k after edge E0+1+k.
- Read: byte k captured at edge E0+2+k. done is high after edge E0+N+2. A word fetch therefore takes 7 cycles from E0 to the end of the done cycle.
- Write: ram_wr is high after edges E0+1 .. E0+N. ram_wr is low and mem_done is high after edge E0+N+1.
- Back-to-back: the earliest next acceptance is edge done+2.
- Simultaneous if_req and mem_req in IDLE: MEM is granted. IF waits, with its stall_req held.

## Configuration
- MEM_ARB_LOAD_EXT_EN defined: sub-word loads are sign- or zero-extended according to mem_load_sign.
- MEM_ARB_LOAD_EXT_EN undefined: mem_load_sign is ignored and loads are always zero-extended. MEM performs extension downstream.

## Test plan
- Reset, then if_req with if_addr=0x100 and RAM bytes 13,12,11,10 at 0x100..0x103 → ram_a steps 0x100..0x103 after edges 1..4; if_done after edge 6 with if_data=0x10111213.
- Same edge: if_req at 0x0 and mem_req store word 0xAABBCCDD at 0x20 → writes DD,CC,BB,AA to 0x20..0x23, mem_done after edge 5, IF accepted at edge 7.
- mem_req load byte at 0x40 holding 0x80 with mem_load_sign=1 → mem_rdata=0xFFFFFF80 with the macro defined, 0x00000080 without it.
- if_flush during the IF_RD cycle at k=2 → no if_done; FSM in IDLE at the next edge; ram_wr never asserted.
- Half store at ADDR_W-bit address 0xFFFFFFFF → bytes written to 0xFFFFFFFF then 0x00000000.
- rst low while ram_wr=1 in MEM_WR → ram_wr=0 immediately; all outputs at reset values; no mem_done after release.
